// File: rtl/acq_sequencer.sv
// acq_sequencer: acquisition/readout controller for one PSEC5 sampling cycle.
// It resets the channel counters, waits for PLL lock and gates the sampling clock
// while armed. After a masked trigger and the programmed delay it stops sampling.
// It then walks every channel x register with a parallel-load strobe followed by
// SHIFT_BITS serializer shift cycles.
// Every output comes from a register. The output decoder looks at the next-state
// values, so the registered outputs always line up with the state register.
module acq_sequencer #(
    parameter int NUM_CH       = 8,
    parameter int NUM_REG      = 7,
    parameter int SHIFT_BITS   = 8,
    parameter int RST_CYCLES   = 4,
    parameter int LOCK_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_rst,
    input  logic              inst_start,
    input  logic              inst_readout,
    input  logic              pll_locked,
    input  logic [NUM_CH-1:0] trig_in,
    input  logic [NUM_CH-1:0] trigger_channel_mask,
    input  logic [7:0]        trig_delay,
    output logic              clk_enable,
    output logic              cnt_rst,
    output logic [NUM_CH-1:0] load_cnt_ser,
    output logic [2:0]        select_reg,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic              err_lock
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = ($clog2(LOCK_TIMEOUT + 1) > 8) ? $clog2(LOCK_TIMEOUT + 1) : 8;

    localparam logic [CNT_W-1:0]  CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  SHIFT_LAST  = CNT_W'(SHIFT_BITS - 1);
    localparam logic [CH_W-1:0]   CH_LAST     = CH_W'(NUM_CH - 1);
    localparam logic [2:0]        REG_LAST    = 3'(NUM_REG - 1);
    localparam logic [NUM_CH-1:0] ONEHOT_BASE = NUM_CH'(1);
    localparam logic [2:0]        SEL_NONE    = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RESET     = 4'd1,
        S_WAIT_LOCK = 4'd2,
        S_ARMED     = 4'd3,
        S_DELAY     = 4'd4,
        S_STOP      = 4'd5,
        S_LOAD      = 4'd6,
        S_SHIFT     = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    state_t           state_r,  state_next_s;
    logic [CNT_W-1:0] cnt_r,    cnt_next_s;
    logic [CH_W-1:0]  ch_r,     ch_next_s;
    logic [2:0]       reg_r,    reg_next_s;
    logic             err_lock_r, err_next_s;

    logic              clk_enable_r,   clk_enable_s;
    logic              cnt_rst_r,      cnt_rst_s;
    logic [NUM_CH-1:0] load_cnt_ser_r, load_cnt_ser_s;
    logic [2:0]        select_reg_r,   select_reg_s;
    logic              shift_en_r,     shift_en_s;
    logic              busy_r,         busy_s;
    logic              done_r,         done_s;

    // State, counter and flag registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            cnt_r      <= CNT_ZERO;
            ch_r       <= '0;
            reg_r      <= 3'd0;
            err_lock_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            ch_r       <= ch_next_s;
            reg_r      <= reg_next_s;
            err_lock_r <= err_next_s;
        end
    end

    // Next-state and counter logic; inst_rst overrides everything, then readout, then start
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        ch_next_s    = ch_r;
        reg_next_s   = reg_r;
        err_next_s   = err_lock_r;
        if (inst_rst) begin
            state_next_s = S_IDLE;
            cnt_next_s   = CNT_ZERO;
            ch_next_s    = '0;
            reg_next_s   = 3'd0;
            err_next_s   = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (inst_readout) begin
                        state_next_s = S_LOAD;
                        cnt_next_s   = CNT_ZERO;
                    end else if (inst_start) begin
                        state_next_s = S_RESET;
                        cnt_next_s   = CNT_ZERO;
                        err_next_s   = 1'b0;
                    end else begin
                        state_next_s = S_IDLE;
                    end
                end
                S_RESET: begin
                    if (cnt_r == RST_LAST) begin
                        state_next_s = S_WAIT_LOCK;
                        cnt_next_s   = CNT_ZERO;
                    end else begin
                        cnt_next_s = cnt_r + CNT_ONE;
                    end
                end
                S_WAIT_LOCK: begin
                    if (pll_locked) begin
                        state_next_s = S_ARMED;
                        cnt_next_s   = CNT_ZERO;
                    end else if (cnt_r == LOCK_LAST) begin
                        state_next_s = S_IDLE;
                        cnt_next_s   = CNT_ZERO;
                        err_next_s   = 1'b1;
                    end else begin
                        cnt_next_s = cnt_r + CNT_ONE;
                    end
                end
                S_ARMED: begin
                    if (inst_readout) begin
                        state_next_s = S_STOP;
                    end else if ((trig_in & trigger_channel_mask) != '0) begin
                        if (trig_delay == 8'd0) begin
                            state_next_s = S_STOP;
                        end else begin
                            state_next_s = S_DELAY;
                            cnt_next_s   = CNT_W'(trig_delay);
                        end
                    end else begin
                        state_next_s = S_ARMED;
                    end
                end
                S_DELAY: begin
                    // The counter holds the cycles left including this one
                    if (inst_readout || (cnt_r <= CNT_ONE)) begin
                        state_next_s = S_STOP;
                        cnt_next_s   = CNT_ZERO;
                    end else begin
                        cnt_next_s = cnt_r - CNT_ONE;
                    end
                end
                S_STOP: begin
                    state_next_s = S_LOAD;
                    cnt_next_s   = CNT_ZERO;
                    ch_next_s    = '0;
                    reg_next_s   = 3'd0;
                end
                S_LOAD: begin
                    state_next_s = S_SHIFT;
                    cnt_next_s   = CNT_ZERO;
                end
                S_SHIFT: begin
                    if (cnt_r == SHIFT_LAST) begin
                        cnt_next_s = CNT_ZERO;
                        if (reg_r == REG_LAST) begin
                            reg_next_s = 3'd0;
                            if (ch_r == CH_LAST) begin
                                ch_next_s    = '0;
                                state_next_s = S_DONE;
                            end else begin
                                ch_next_s    = ch_r + CH_W'(1);
                                state_next_s = S_LOAD;
                            end
                        end else begin
                            reg_next_s   = reg_r + 3'd1;
                            state_next_s = S_LOAD;
                        end
                    end else begin
                        cnt_next_s = cnt_r + CNT_ONE;
                    end
                end
                S_DONE: begin
                    state_next_s = S_IDLE;
                end
                default: begin
                    state_next_s = S_IDLE;
                    cnt_next_s   = CNT_ZERO;
                    ch_next_s    = '0;
                    reg_next_s   = 3'd0;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so the output registers track state_r
    always_comb begin
        clk_enable_s   = 1'b0;
        cnt_rst_s      = 1'b0;
        load_cnt_ser_s = '0;
        select_reg_s   = SEL_NONE;
        shift_en_s     = 1'b0;
        busy_s         = 1'b1;
        done_s         = 1'b0;
        case (state_next_s)
            S_IDLE:      busy_s       = 1'b0;
            S_RESET:     cnt_rst_s    = 1'b1;
            S_WAIT_LOCK: busy_s       = 1'b1;
            S_ARMED:     clk_enable_s = 1'b1;
            S_DELAY:     clk_enable_s = 1'b1;
            S_STOP:      busy_s       = 1'b1;
            S_LOAD: begin
                load_cnt_ser_s = ONEHOT_BASE << ch_next_s;
                select_reg_s   = reg_next_s;
            end
            S_SHIFT: begin
                select_reg_s = reg_next_s;
                shift_en_s   = 1'b1;
            end
            S_DONE:      done_s       = 1'b1;
            default:     busy_s       = 1'b0;
        endcase
    end

    // Output registers with synchronous reset to the idle decode
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_enable_r   <= 1'b0;
            cnt_rst_r      <= 1'b0;
            load_cnt_ser_r <= '0;
            select_reg_r   <= SEL_NONE;
            shift_en_r     <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            clk_enable_r   <= clk_enable_s;
            cnt_rst_r      <= cnt_rst_s;
            load_cnt_ser_r <= load_cnt_ser_s;
            select_reg_r   <= select_reg_s;
            shift_en_r     <= shift_en_s;
            busy_r         <= busy_s;
            done_r         <= done_s;
        end
    end

    assign clk_enable   = clk_enable_r;
    assign cnt_rst      = cnt_rst_r;
    assign load_cnt_ser = load_cnt_ser_r;
    assign select_reg   = select_reg_r;
    assign shift_en     = shift_en_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err_lock     = err_lock_r;

endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: randomized bench for acq_sequencer. The expected output vector
// for every cycle comes from the phase timeline of an acquisition. The readout
// position is derived from the readout cycle index with plain division.
module tb_acq_sequencer;

    localparam int RO_CYCLES = 8 * 7 * 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       inst_rst, inst_start, inst_readout, pll_locked;
    logic [7:0] trig_in, trigger_channel_mask, trig_delay;
    logic       clk_enable, cnt_rst, shift_en, busy, done, err_lock;
    logic [7:0] load_cnt_ser;
    logic [2:0] select_reg;

    int n_tests = 0;
    int n_fail  = 0;

    acq_sequencer dut (
        .clk(clk), .rst(rst),
        .inst_rst(inst_rst), .inst_start(inst_start), .inst_readout(inst_readout),
        .pll_locked(pll_locked), .trig_in(trig_in),
        .trigger_channel_mask(trigger_channel_mask), .trig_delay(trig_delay),
        .clk_enable(clk_enable), .cnt_rst(cnt_rst), .load_cnt_ser(load_cnt_ser),
        .select_reg(select_reg), .shift_en(shift_en), .busy(busy), .done(done),
        .err_lock(err_lock)
    );

    // Free-running clock
    always #5 clk = ~clk;

    logic [16:0] obs_s;
    assign obs_s = {clk_enable, cnt_rst, load_cnt_ser, select_reg, shift_en, busy, done, err_lock};

    function automatic logic [16:0] vec(input logic ce, input logic cr, input logic [7:0] ld,
                                        input logic [2:0] sel, input logic sh, input logic bz,
                                        input logic dn, input logic el);
        return {ce, cr, ld, sel, sh, bz, dn, el};
    endfunction

    function automatic logic [16:0] idle_vec(input logic el);
        return vec(1'b0, 1'b0, 8'h00, 3'b111, 1'b0, 1'b0, 1'b0, el);
    endfunction

    task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        inst_rst     = 1'b0;
        inst_start   = 1'b0;
        inst_readout = 1'b0;
    endtask

    // Readout walk from its first LOAD cycle; abort_at >= 0 issues inst_rst at that cycle
    task automatic readout_seq(input int abort_at);
        for (int k = 0; k < RO_CYCLES; k++) begin
            int ch, rg, sub;
            logic [7:0] oh;
            ch  = k / 63;
            rg  = (k / 9) % 7;
            sub = k % 9;
            oh  = 8'd1 << ch;
            check_eq($sformatf("readout k=%0d", k), obs_s,
                     vec(1'b0, 1'b0, (sub == 0) ? oh : 8'h00, 3'(rg), sub != 0, 1'b1, 1'b0, 1'b0));
            inst_start   = 1'($urandom);
            inst_readout = 1'($urandom);
            trig_in      = 8'($urandom);
            if (k == abort_at) begin
                inst_rst = 1'b1;
                step();
                clear_pulses();
                check_eq("abort_idle", obs_s, idle_vec(1'b0));
                step();
                check_eq("abort_no_done", obs_s, idle_vec(1'b0));
                return;
            end
            step();
        end
        clear_pulses();
        check_eq("done_pulse", obs_s, vec(1'b0, 1'b0, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0));
        step();
        check_eq("idle_after_done", obs_s, idle_vec(1'b0));
        step();
        check_eq("done_once", obs_s, idle_vec(1'b0));
    endtask

    // One acquisition from IDLE: start, counter reset, lock wait, arm, trigger or forced readout
    task automatic run_acq(input int dly, input logic [7:0] msk, input logic [7:0] trg,
                           input int lock_wait, input int arm_wait, input bit force_ro,
                           input int abort_at);
        trig_delay           = 8'(dly);
        trigger_channel_mask = msk;
        trig_in              = 8'h00;
        pll_locked           = (lock_wait == 0);
        inst_start           = 1'b1;
        step();
        inst_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("reset_phase", obs_s, vec(1'b0, 1'b1, 8'h00, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0));
            step();
        end
        for (int i = 0; i < lock_wait; i++) begin
            check_eq("wait_lock", obs_s, vec(1'b0, 1'b0, 8'h00, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0));
            step();
        end
        pll_locked = 1'b1;
        check_eq("wait_lock_last", obs_s, vec(1'b0, 1'b0, 8'h00, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0));
        step();
        for (int i = 0; i < arm_wait; i++) begin
            trig_in    = 8'($urandom) & ~msk;
            inst_start = 1'($urandom);
            check_eq("armed_hold", obs_s, vec(1'b1, 1'b0, 8'h00, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0));
            step();
        end
        inst_start = 1'b0;
        if (force_ro) begin
            trig_in      = 8'h00;
            inst_readout = 1'b1;
            check_eq("armed_force", obs_s, vec(1'b1, 1'b0, 8'h00, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0));
            step();
            inst_readout = 1'b0;
        end else begin
            trig_in = trg;
            check_eq("armed_trig", obs_s, vec(1'b1, 1'b0, 8'h00, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0));
            step();
            for (int i = 0; i < dly; i++) begin
                trig_in    = 8'($urandom);
                trig_delay = 8'($urandom);
                check_eq($sformatf("delay i=%0d", i), obs_s,
                         vec(1'b1, 1'b0, 8'h00, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0));
                step();
            end
        end
        trig_in = 8'($urandom);
        check_eq("stop", obs_s, vec(1'b0, 1'b0, 8'h00, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0));
        step();
        readout_seq(abort_at);
    endtask

    initial begin
        // Reset with random inputs, including an inst_start that must be ignored
        rst                  = 1'b1;
        inst_rst             = 1'($urandom);
        inst_start           = 1'b1;
        inst_readout         = 1'($urandom);
        pll_locked           = 1'($urandom);
        trig_in              = 8'($urandom);
        trigger_channel_mask = 8'($urandom);
        trig_delay           = 8'($urandom);
        step();
        check_eq("reset_c1", obs_s, idle_vec(1'b0));
        step();
        check_eq("reset_c2", obs_s, idle_vec(1'b0));
        rst = 1'b0;
        clear_pulses();
        trig_in = 8'h00;
        step();
        check_eq("reset_release", obs_s, idle_vec(1'b0));

        // Nominal acquisition
        run_acq(5, 8'b0010_1001, 8'b0000_1000, 0, 10, 1'b0, -1);

        // Masked-out hits keep ARMED; an enabled hit with zero delay stops next cycle
        run_acq(0, 8'b0000_0001, 8'b0000_0001, 3, 20, 1'b0, -1);

        // Lock timeout, sticky error, then cleared by the next start
        pll_locked = 1'b0;
        inst_start = 1'b1;
        step();
        inst_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("to_reset", obs_s, vec(1'b0, 1'b1, 8'h00, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0));
            step();
        end
        for (int i = 0; i < 1023; i++) begin
            check_eq("to_wait", obs_s, vec(1'b0, 1'b0, 8'h00, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0));
            step();
        end
        check_eq("to_err", obs_s, idle_vec(1'b1));
        step();
        check_eq("to_err_sticky", obs_s, idle_vec(1'b1));
        inst_start = 1'b1;
        step();
        inst_start = 1'b0;
        check_eq("to_err_clear", obs_s, vec(1'b0, 1'b1, 8'h00, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0));
        inst_rst = 1'b1;
        step();
        inst_rst = 1'b0;
        check_eq("rst_from_reset", obs_s, idle_vec(1'b0));

        // Abort at readout cycle 100
        run_acq(3, 8'hFF, 8'h80, 0, 2, 1'b0, 100);

        // inst_rst wins over inst_start
        inst_rst   = 1'b1;
        inst_start = 1'b1;
        step();
        clear_pulses();
        check_eq("prio_rst_start", obs_s, idle_vec(1'b0));
        step();
        check_eq("prio_rst_start_hold", obs_s, idle_vec(1'b0));

        // Forced readout from ARMED
        run_acq(4, 8'hFF, 8'h01, 0, 5, 1'b1, -1);

        // Readout straight from IDLE; inst_readout outranks a coincident inst_start
        inst_readout = 1'b1;
        inst_start   = 1'b1;
        step();
        clear_pulses();
        readout_seq(-1);

        // Randomized acquisitions
        for (int it = 0; it < 6; it++) begin
            logic [7:0] msk, trg;
            msk = 8'($urandom_range(1, 255));
            trg = 8'($urandom) & msk;
            if (trg == 8'h00) trg = msk;
            run_acq($urandom_range(0, 12), msk, trg, $urandom_range(0, 20),
                    $urandom_range(0, 15), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, RO_CYCLES - 1) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
